// File: rtl/loopback_pkg.sv
// ---------------------------------------------------------------------------
// loopback_pkg
// Shared types and constants for the HPIO RX loopback checker.
//   chk_state_t : checker FSM states (IDLE, SEARCH, LOCKED)
//   WORD_W      : deserialized word width
//   OFFSET_W    : width of the bit-rotation offset
//   popcount8   : number of set bits in one word (bit-error accounting)
// ---------------------------------------------------------------------------
package loopback_pkg;

  localparam int unsigned WORD_W   = 8;
  localparam int unsigned OFFSET_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Count of ones in a word; result fits in 4 bits for an 8-bit word.
  function automatic logic [3:0] popcount8(input logic [WORD_W-1:0] w);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      n = n + 4'(w[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/loopback_checker_if.sv
// ---------------------------------------------------------------------------
// loopback_checker_if
// Word stream bundle between the RX FIFO read side and the checker.
//   rx_data      : raw RX word from the FIFO
//   rx_valid     : rx_data valid this cycle (one beat)
//   data_out     : aligned word produced by the checker
//   data_out_vld : data_out valid
// Modports:
//   master : source side (drives rx_*, observes data_out*)
//   slave  : checker side (consumes rx_*, drives data_out*)
// ---------------------------------------------------------------------------
interface loopback_checker_if;
  import loopback_pkg::*;

  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic [WORD_W-1:0] data_out;
  logic              data_out_vld;

  modport master (
    output rx_data,
    output rx_valid,
    input  data_out,
    input  data_out_vld
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output data_out,
    output data_out_vld
  );

endinterface

// File: rtl/loopback_checker_word_aligner.sv
// ---------------------------------------------------------------------------
// word_aligner
// Keeps the previous raw word and selects an 8-bit window out of
// {current, previous} at the requested bit offset. The aligned word is
// offered combinationally to the checker and registered onto data_out.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_data          : raw RX word
//   i_valid         : beat strobe
//   i_active        : checker is out of IDLE and enabled; gates data_out_vld
//   i_offset        : bit offset 0..7 into the 16-bit window
//   o_aligned_c     : combinational aligned word for the current beat
//   o_data_out      : registered aligned word
//   o_data_out_vld  : registered valid, one cycle after the beat
// ---------------------------------------------------------------------------
module word_aligner
  import loopback_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   i_data,
  input  logic                i_valid,
  input  logic                i_active,
  input  logic [OFFSET_W-1:0] i_offset,
  output logic [WORD_W-1:0]   o_aligned_c,
  output logic [WORD_W-1:0]   o_data_out,
  output logic                o_data_out_vld
);

  logic [WORD_W-1:0]   r_prev_raw;
  logic [WORD_W-1:0]   r_data_out;
  logic                r_data_out_vld;
  logic [2*WORD_W-1:0] w_win;

  // Offset 0 selects the previous word whole; higher offsets pull bits
  // down from the current word.
  assign w_win       = {i_data, r_prev_raw};
  assign o_aligned_c = w_win[i_offset +: WORD_W];

  // History word tracks every beat, even while the checker is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_raw     <= '0;
      r_data_out     <= '0;
      r_data_out_vld <= 1'b0;
    end else begin
      r_data_out_vld <= i_valid & i_active;
      if (i_valid) begin
        r_prev_raw <= i_data;
      end
      if (i_valid & i_active) begin
        r_data_out <= o_aligned_c;
      end
    end
  end

  assign o_data_out     = r_data_out;
  assign o_data_out_vld = r_data_out_vld;

endmodule

// File: rtl/loopback_checker.sv
// ---------------------------------------------------------------------------
// loopback_checker
// Locks onto the bit rotation at which the RX stream becomes an incrementing
// mod-256 counter, then checks every word against a free-running expected
// count and keeps word / error / slip / lock-loss statistics.
// Parameters:
//   LOCK_COUNT : consecutive in-sequence words needed to lock
//   LOSS_COUNT : consecutive mismatches that drop lock
//   CNT_W      : statistics counter width (saturating)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_enable        : 0 holds the FSM in IDLE; statistics are kept
//   i_clear_cnt     : synchronous clear of all statistics counters
//   bus (slave)     : rx_data/rx_valid in, data_out/data_out_vld out
//   o_locked        : FSM is in LOCKED
//   o_align_offset  : current bit offset
//   o_word_cnt      : words checked while LOCKED
//   o_err_cnt       : mismatching words while LOCKED
//   o_slip_cnt      : offset increments made while searching
//   o_lost_cnt      : LOCKED -> SEARCH transitions
//   o_bit_err_cnt   : bit errors accumulated on LOCKED mismatches
//                     (only with LOOPBACK_CHK_BITERR_EN defined)
// ---------------------------------------------------------------------------
module loopback_checker
  import loopback_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_clear_cnt,
  loopback_checker_if.slave   bus,
  output logic                o_locked,
  output logic [OFFSET_W-1:0] o_align_offset,
  output logic [CNT_W-1:0]    o_word_cnt,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic [CNT_W-1:0]    o_slip_cnt,
  output logic [CNT_W-1:0]    o_lost_cnt
`ifdef LOOPBACK_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0]    o_bit_err_cnt
`endif
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CERR_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t          r_state;
  chk_state_t          w_state_next;

  logic                r_locked;
  logic                r_prime;
  logic [WORD_W-1:0]   r_last;
  logic [WORD_W-1:0]   r_expect;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [CERR_W-1:0]   r_consec_err;
  logic [OFFSET_W-1:0] r_offset;

  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_slip_cnt;
  logic [CNT_W-1:0]    r_lost_cnt;

  logic                w_beat;
  logic                w_active;
  logic [WORD_W-1:0]   w_aligned;
  logic                w_seq_ok;
  logic                w_exp_ok;
  logic [MATCH_W-1:0]  w_match_inc;
  logic [CERR_W-1:0]   w_cerr_inc;
  logic                w_lock_hit;
  logic                w_loss_hit;

  // Per-beat action strobes decoded from the state.
  logic                w_enter_search;
  logic                w_store_last;
  logic                w_match_step;
  logic                w_slip;
  logic                w_word;
  logic                w_good;
  logic                w_err;
  logic                w_lost;
  logic                w_lock;

  assign w_beat   = bus.rx_valid;
  assign w_active = i_enable & (r_state != IDLE);

  word_aligner u_aligner (
    .clk            (clk),
    .rst            (rst),
    .i_data         (bus.rx_data),
    .i_valid        (bus.rx_valid),
    .i_active       (w_active),
    .i_offset       (r_offset),
    .o_aligned_c    (w_aligned),
    .o_data_out     (bus.data_out),
    .o_data_out_vld (bus.data_out_vld)
  );

  // Compare terms; sequence arithmetic wraps naturally at 8 bits.
  assign w_seq_ok    = (w_aligned == WORD_W'(r_last + 1'b1));
  assign w_exp_ok    = (w_aligned == r_expect);
  assign w_match_inc = r_match_cnt + MATCH_W'(1);
  assign w_cerr_inc  = r_consec_err + CERR_W'(1);
  assign w_lock_hit  = (w_match_inc == MATCH_W'(LOCK_COUNT));
  assign w_loss_hit  = (w_cerr_inc == CERR_W'(LOSS_COUNT));
  assign w_lock      = w_match_step & w_lock_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; disable wins over any beat.
  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = IDLE;
    end else if (w_beat) begin
      case (r_state)
        IDLE:    w_state_next = SEARCH;
        SEARCH:  if (!r_prime && w_seq_ok && w_lock_hit) w_state_next = LOCKED;
        LOCKED:  if (!w_exp_ok && w_loss_hit) w_state_next = SEARCH;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output decode: one-hot-ish action strobes for the datapath and counters.
  always_comb begin
    w_enter_search = 1'b0;
    w_store_last   = 1'b0;
    w_match_step   = 1'b0;
    w_slip         = 1'b0;
    w_word         = 1'b0;
    w_good         = 1'b0;
    w_err          = 1'b0;
    w_lost         = 1'b0;
    if (i_enable && w_beat) begin
      case (r_state)
        IDLE: w_enter_search = 1'b1;
        SEARCH: begin
          if (r_prime)       w_store_last = 1'b1;
          else if (w_seq_ok) w_match_step = 1'b1;
          else               w_slip       = 1'b1;
        end
        LOCKED: begin
          w_word = 1'b1;
          if (w_exp_ok) begin
            w_good = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_lost = w_loss_hit;
          end
        end
        default: ;
      endcase
    end
  end

  // Search / tracking datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked     <= 1'b0;
      r_prime      <= 1'b0;
      r_last       <= '0;
      r_expect     <= '0;
      r_match_cnt  <= '0;
      r_consec_err <= '0;
      r_offset     <= '0;
    end else begin
      r_locked <= (w_state_next == LOCKED);
      if (w_enter_search || w_lost) begin
        r_prime     <= 1'b1;
        r_match_cnt <= '0;
      end
      if (w_store_last) begin
        r_last  <= w_aligned;
        r_prime <= 1'b0;
      end
      if (w_match_step) begin
        r_match_cnt <= w_match_inc;
        r_last      <= w_aligned;
      end
      if (w_slip) begin
        r_offset    <= r_offset + OFFSET_W'(1);
        r_match_cnt <= '0;
        r_prime     <= 1'b1;
      end
      // Expected count is seeded once at lock and then free-runs per beat.
      if (w_lock) begin
        r_expect     <= WORD_W'(w_aligned + 1'b1);
        r_consec_err <= '0;
      end
      if (w_word) r_expect <= WORD_W'(r_expect + 1'b1);
      if (w_good) r_consec_err <= '0;
      if (w_err)  r_consec_err <= w_cerr_inc;
    end
  end

  // Saturating statistics; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_slip_cnt <= '0;
      r_lost_cnt <= '0;
    end else if (i_clear_cnt) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_slip_cnt <= '0;
      r_lost_cnt <= '0;
    end else begin
      if (w_word && (r_word_cnt != CNT_MAX)) r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_err  && (r_err_cnt  != CNT_MAX)) r_err_cnt  <= r_err_cnt  + CNT_W'(1);
      if (w_slip && (r_slip_cnt != CNT_MAX)) r_slip_cnt <= r_slip_cnt + CNT_W'(1);
      if (w_lost && (r_lost_cnt != CNT_MAX)) r_lost_cnt <= r_lost_cnt + CNT_W'(1);
    end
  end

`ifdef LOOPBACK_CHK_BITERR_EN
  logic [CNT_W-1:0] r_bit_err_cnt;
  logic [CNT_W:0]   w_bit_sum;

  // One extra bit catches overflow so the sum can clamp at CNT_MAX.
  assign w_bit_sum = {1'b0, r_bit_err_cnt} + (CNT_W + 1)'(popcount8(w_aligned ^ r_expect));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_err_cnt <= '0;
    end else if (i_clear_cnt) begin
      r_bit_err_cnt <= '0;
    end else if (w_err) begin
      r_bit_err_cnt <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
    end
  end

  assign o_bit_err_cnt = r_bit_err_cnt;
`else
  // Bit-error accounting is not built in this configuration.
`endif

  assign o_locked       = r_locked;
  assign o_align_offset = r_offset;
  assign o_word_cnt     = r_word_cnt;
  assign o_err_cnt      = r_err_cnt;
  assign o_slip_cnt     = r_slip_cnt;
  assign o_lost_cnt     = r_lost_cnt;

endmodule

// File: tb/tb_loopback_checker.sv
// ---------------------------------------------------------------------------
// tb_loopback_checker
// Scoreboard bench: the stimulus process feeds a behavioural model that
// pushes every expected aligned output word into a queue; a monitor pops
// and compares whenever data_out_vld is seen. Status outputs are compared
// against the model after every clock.
// ---------------------------------------------------------------------------
module tb_loopback_checker;

  localparam int unsigned LOCK_COUNT = 16;
  localparam int unsigned LOSS_COUNT = 4;
  localparam int unsigned CNT_W      = 32;
  localparam longint      CNT_MAXV   = (longint'(1) << CNT_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              clear_cnt;
  logic              locked;
  logic [2:0]        align_offset;
  logic [CNT_W-1:0]  word_cnt, err_cnt, slip_cnt, lost_cnt;
`ifdef LOOPBACK_CHK_BITERR_EN
  logic [CNT_W-1:0]  bit_err_cnt;
`endif

  loopback_checker_if bus ();

  loopback_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (LOSS_COUNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (enable),
    .i_clear_cnt    (clear_cnt),
    .bus            (bus),
    .o_locked       (locked),
    .o_align_offset (align_offset),
    .o_word_cnt     (word_cnt),
    .o_err_cnt      (err_cnt),
    .o_slip_cnt     (slip_cnt),
    .o_lost_cnt     (lost_cnt)
`ifdef LOOPBACK_CHK_BITERR_EN
    ,
    .o_bit_err_cnt  (bit_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers).
  int     m_st, m_off, m_prev, m_last, m_prime, m_mcnt, m_exp, m_cerr;
  longint m_word, m_err, m_slip, m_lost, m_bit;
  int     exp_q[$];

  // Stream generator: TX counter and rotation applied on the wire.
  int tx_cur, tx_last, rot;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > CNT_MAXV) ? CNT_MAXV : v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_off = 0; m_prev = 0; m_last = 0; m_prime = 0;
    m_mcnt = 0; m_exp = 0; m_cerr = 0;
    m_word = 0; m_err = 0; m_slip = 0; m_lost = 0; m_bit = 0;
  endtask

  // One clock of behaviour as described by the checker rules.
  task automatic model_step(input int rx, input bit vld, input bit en, input bit clr);
    int al;
    al = ((rx * 256 + m_prev) >> m_off) & 255;
    if (vld && en && m_st != M_IDLE) exp_q.push_back(al);
    if (!en) begin
      m_st = M_IDLE;
    end else if (vld) begin
      if (m_st == M_IDLE) begin
        m_st = M_SEARCH; m_prime = 1; m_mcnt = 0;
      end else if (m_st == M_SEARCH) begin
        if (m_prime != 0) begin
          m_last = al; m_prime = 0;
        end else if (al == ((m_last + 1) % 256)) begin
          m_mcnt++; m_last = al;
          if (m_mcnt == LOCK_COUNT) begin
            m_st = M_LOCKED; m_exp = (al + 1) % 256; m_cerr = 0;
          end
        end else begin
          m_off = (m_off + 1) % 8; m_mcnt = 0; m_prime = 1; m_slip = sat(m_slip + 1);
        end
      end else begin
        m_word = sat(m_word + 1);
        if (al != m_exp) begin
          m_err = sat(m_err + 1);
          m_bit = sat(m_bit + $countones(al ^ m_exp));
          m_cerr++;
          if (m_cerr == LOSS_COUNT) begin
            m_st = M_SEARCH; m_lost = sat(m_lost + 1); m_prime = 1; m_mcnt = 0;
          end
        end else begin
          m_cerr = 0;
        end
        m_exp = (m_exp + 1) % 256;
      end
    end
    if (vld) m_prev = rx;
    if (clr) begin
      m_word = 0; m_err = 0; m_slip = 0; m_lost = 0; m_bit = 0;
    end
  endtask

  task automatic check_status();
    check("locked", longint'(locked), (m_st == M_LOCKED) ? 1 : 0);
    check("align_offset", longint'(align_offset), m_off);
    check("word_cnt", longint'(word_cnt), m_word);
    check("err_cnt", longint'(err_cnt), m_err);
    check("slip_cnt", longint'(slip_cnt), m_slip);
    check("lost_cnt", longint'(lost_cnt), m_lost);
`ifdef LOOPBACK_CHK_BITERR_EN
    check("bit_err_cnt", longint'(bit_err_cnt), m_bit);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, longint'(bus.data_out), 0);
    check({tag, "_data_out_vld"}, longint'(bus.data_out_vld), 0);
    check({tag, "_locked"}, longint'(locked), 0);
    check({tag, "_align_offset"}, longint'(align_offset), 0);
    check({tag, "_word_cnt"}, longint'(word_cnt), 0);
    check({tag, "_err_cnt"}, longint'(err_cnt), 0);
    check({tag, "_slip_cnt"}, longint'(slip_cnt), 0);
    check({tag, "_lost_cnt"}, longint'(lost_cnt), 0);
`ifdef LOOPBACK_CHK_BITERR_EN
    check({tag, "_bit_err_cnt"}, longint'(bit_err_cnt), 0);
`endif
  endtask

  // Drive one clock (inputs set just after the previous edge).
  task automatic cycle(input int rx, input bit vld, input bit clr);
    bus.rx_data  = 8'(rx);
    bus.rx_valid = vld;
    clear_cnt    = clr;
    model_step(rx, vld, enable, clr);
    @(posedge clk);
    #1;
    check_status();
    bus.rx_valid = 1'b0;
    clear_cnt    = 1'b0;
  endtask

  // Next counter word, rotated by rot bits, optionally corrupted by mask.
  task automatic send_word(input int mask, input bit clr);
    int rx;
    rx = (((tx_cur << rot) | (tx_last >> (8 - rot))) & 255) ^ mask;
    tx_last = tx_cur;
    tx_cur  = (tx_cur + 1) % 256;
    cycle(rx, 1'b1, clr);
  endtask

  task automatic start_stream(input int first, input int r);
    tx_cur  = first;
    tx_last = (first + 255) % 256;
    rot     = r;
  endtask

  task automatic run_until_lock(input int bound, input string tag);
    int n;
    n = 0;
    while (m_st != M_LOCKED && n < bound) begin
      send_word(0, 1'b0);
      n++;
    end
    check({tag, "_locked"}, longint'(locked), 1);
  endtask

  task automatic pulse_reset(input string tag);
    cycle(0, 1'b0, 1'b0);     // let the last output word drain
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    #2;
    rst = 1'b0;
    check({tag, "_queue_empty"}, longint'(exp_q.size()), 0);
    exp_q.delete();
    model_reset();
  endtask

  // Output monitor: every presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.data_out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL data_out: unexpected word %0d with empty queue (t=%0t)", bus.data_out, $time);
      end else begin
        check("data_out", longint'(bus.data_out), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    longint w0, e0;
    int     nb;
    rst = 1'b1; enable = 1'b0; clear_cnt = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    model_reset();
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Offset 0: plain counter from 0 locks at offset 0 with no errors.
    enable = 1'b1;
    start_stream(0, 0);
    for (int i = 0; i < int'(LOCK_COUNT) + 4; i++) send_word(0, 1'b0);
    check("t1_locked", longint'(locked), 1);
    check("t1_offset", longint'(align_offset), 0);
    check("t1_err", longint'(err_cnt), 0);

    // Rotation 3 from a random start: three slips, then lock at offset 3.
    pulse_reset("t2_rst");
    start_stream(int'($urandom_range(0, 255)), 3);
    run_until_lock(200, "t2");
    check("t2_offset", longint'(align_offset), 3);
    check("t2_slip", longint'(slip_cnt), 3);
    for (int i = 0; i < 5; i++) send_word(0, 1'b0);

    // Single word corrupted by 8'h05: one error, lock held.
    send_word(8'h05, 1'b0);
    for (int i = 0; i < 3; i++) send_word(0, 1'b0);
    check("t3_err", longint'(err_cnt), 1);
    check("t3_locked", longint'(locked), 1);
`ifdef LOOPBACK_CHK_BITERR_EN
    check("t3_bit_err", longint'(bit_err_cnt), 2);
`endif

    // LOSS_COUNT consecutive bad words drop lock; clean stream relocks.
    for (int i = 0; i < int'(LOSS_COUNT); i++) begin
      if (i == int'(LOSS_COUNT) - 1) check("t4_still_locked", longint'(locked), 1);
      send_word(8'hFF, 1'b0);
    end
    check("t4_unlocked", longint'(locked), 0);
    check("t4_lost", longint'(lost_cnt), 1);
    run_until_lock(300, "t4_relock");
    check("t4_offset", longint'(align_offset), 3);

    // Gapped stream long enough to cross FF->00 at least once.
    w0 = m_word; e0 = m_err; nb = 260;
    for (int i = 0; i < nb; i++) begin
      send_word(0, 1'b0);
      cycle(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    check("t5_err", longint'(err_cnt), e0);
    check("t5_words", longint'(word_cnt), w0 + nb);

    // Clear together with an error: counter ends at 0.
    send_word(8'h05, 1'b1);
    check("t6_err_cleared", longint'(err_cnt), 0);
    check("t6_word_cleared", longint'(word_cnt), 0);
    for (int i = 0; i < 5; i++) send_word(0, 1'b0);

    // Disable: FSM to IDLE, offset and counters held.
    enable = 1'b0;
    send_word(0, 1'b0);
    send_word(0, 1'b0);
    check("t7_locked", longint'(locked), 0);
    check("t7_offset", longint'(align_offset), 3);
    check("t7_word_hold", longint'(word_cnt), 5);
    enable = 1'b1;
    run_until_lock(200, "t7_relock");

    // Random-rotation run, then asynchronous reset mid-LOCKED.
    for (int i = 0; i < 4; i++) send_word(0, 1'b0);
    pulse_reset("t8_rst");
    start_stream(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    run_until_lock(300, "t8");
    for (int i = 0; i < 10; i++) send_word(int'($urandom_range(0, 1)) * int'($urandom_range(1, 255)), 1'b0);

    cycle(0, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0);
    check("final_queue_empty", longint'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
